// File: rtl/comparator_seq.sv
// Sequential WIDTH-bit magnitude comparator, CHUNK bits per cycle, MSB chunk first.
// Result uses the ALU 4-bit format {0, gt, lt, eq}; cout is always 0.
module comparator_seq #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHUNK      = 4,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             sgn,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       out,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx;
  logic             gt;
  logic             lt;

  logic [CHUNK-1:0] a_ch [NCHUNK];
  logic [CHUNK-1:0] b_ch [NCHUNK];
  logic [CHUNK-1:0] chunk_a_c;
  logic [CHUNK-1:0] chunk_b_c;
  logic             chunk_gt_c;
  logic             chunk_lt_c;
  logic             gt_n_c;
  logic             lt_n_c;
  logic             last_c;

  // Split latched operands into chunks and compare the one selected by idx.
  always_comb begin
    for (int i = 0; i < int'(NCHUNK); i++) begin
      a_ch[i] = a_q[i*CHUNK +: CHUNK];
      b_ch[i] = b_q[i*CHUNK +: CHUNK];
    end
    chunk_a_c  = a_ch[idx];
    chunk_b_c  = b_ch[idx];
    chunk_gt_c = chunk_a_c > chunk_b_c;
    chunk_lt_c = chunk_a_c < chunk_b_c;
    // Flags are sticky once the first differing chunk has been seen.
    gt_n_c     = gt | (~(gt | lt) & chunk_gt_c);
    lt_n_c     = lt | (~(gt | lt) & chunk_lt_c);
    last_c     = (EARLY_EXIT && (chunk_gt_c || chunk_lt_c)) || (idx == '0);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out       <= 4'b0000;
      out_valid <= 1'b0;
      cout      <= 1'b0;
      idx       <= '0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Flipping both MSBs maps two's-complement order onto unsigned order.
            a_q      <= num1 ^ (sgn ? MSB_MASK : '0);
            b_q      <= num2 ^ (sgn ? MSB_MASK : '0);
            idx      <= IDX_W'(NCHUNK - 1);
            gt       <= 1'b0;
            lt       <= 1'b0;
            in_ready <= 1'b0;
            state    <= CMP;
          end
        end
        CMP: begin
          gt <= gt_n_c;
          lt <= lt_n_c;
          if (last_c) begin
            out       <= {1'b0, gt_n_c, lt_n_c, ~gt_n_c & ~lt_n_c};
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_seq.sv
// Scoreboard bench for comparator_seq across four chunking/early-exit configurations.
module tb_comparator_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] num1;
  logic [15:0] num2;
  logic        sgn;
  logic [3:0]  iv;
  logic [3:0]  ordy;
  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [3:0]  co;
  logic [3:0]  outv [4];

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] res;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  comparator_seq #(.WIDTH(16), .CHUNK(4),  .EARLY_EXIT(1'b1)) u_d0 (
    .clk(clk), .rst(rst), .num1(num1), .num2(num2), .sgn(sgn), .in_valid(iv[0]),
    .in_ready(ir[0]), .out(outv[0]), .cout(co[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
  comparator_seq #(.WIDTH(16), .CHUNK(4),  .EARLY_EXIT(1'b0)) u_d1 (
    .clk(clk), .rst(rst), .num1(num1), .num2(num2), .sgn(sgn), .in_valid(iv[1]),
    .in_ready(ir[1]), .out(outv[1]), .cout(co[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
  comparator_seq #(.WIDTH(16), .CHUNK(1),  .EARLY_EXIT(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .num1(num1), .num2(num2), .sgn(sgn), .in_valid(iv[2]),
    .in_ready(ir[2]), .out(outv[2]), .cout(co[2]), .out_valid(ov[2]), .out_ready(ordy[2]));
  comparator_seq #(.WIDTH(16), .CHUNK(16), .EARLY_EXIT(1'b0)) u_d3 (
    .clk(clk), .rst(rst), .num1(num1), .num2(num2), .sgn(sgn), .in_valid(iv[3]),
    .in_ready(ir[3]), .out(outv[3]), .cout(co[3]), .out_valid(ov[3]), .out_ready(ordy[3]));

  function automatic int chunk_of(input int d);
    case (d)
      2:       return 1;
      3:       return 16;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic g, l;
    if (s) begin
      g = $signed(a) > $signed(b);
      l = $signed(a) < $signed(b);
    end else begin
      g = a > b;
      l = a < b;
    end
    return {1'b0, g, l, !g && !l};
  endfunction

  function automatic int k_of(input int d, input logic [15:0] a, input logic [15:0] b);
    int c, n, cnt;
    logic [31:0] mask, ca, cb;
    c = chunk_of(d);
    n = 16 / c;
    if (d != 0) return n;
    mask = (32'd1 << c) - 32'd1;
    cnt = 0;
    for (int i = n - 1; i >= 0; i--) begin
      cnt++;
      ca = ({16'd0, a} >> (i * c)) & mask;
      cb = ({16'd0, b} >> (i * c)) & mask;
      if (ca != cb) return cnt;
    end
    return cnt;
  endfunction

  // One full transaction on DUT d; holds out_ready low for 'hold' cycles in DONE.
  task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    num1 = a; num2 = b; sgn = s;
    vectors++;
    if (ir[d] !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_accept d%0d: in_ready=%b required 1", d, ir[d]);
    end
    iv[d] = 1'b1;
    sb.push_back('{res: model(a, b, s), lat: k_of(d, a, b)});
    @(posedge clk); #1;
    iv[d] = 1'b0;
    num1 = 16'($urandom); num2 = 16'($urandom); sgn = 1'($urandom);
    vectors++;
    if (ir[d] !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_after_accept d%0d: in_ready=%b required 0", d, ir[d]);
    end
    n = 0;
    while (ov[d] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    vectors++;
    if (n >= 100) begin
      miscompares++;
      $display("FAIL timeout d%0d: out_valid never rose", d);
      return;
    end
    if (outv[d] !== e.res) begin
      miscompares++;
      $display("FAIL result d%0d a=%h b=%h sgn=%b: out=%b required %b", d, a, b, s, outv[d], e.res);
    end
    vectors++;
    if (n != e.lat) begin
      miscompares++;
      $display("FAIL latency d%0d a=%h b=%h: got %0d cycles required %0d", d, a, b, n, e.lat);
    end
    vectors++;
    if (co[d] !== 1'b0) begin
      miscompares++;
      $display("FAIL cout d%0d: cout=%b required 0", d, co[d]);
    end
    for (int h = 0; h < hold; h++) begin
      iv[d] = (h % 2 == 0);
      @(posedge clk); #1;
      vectors++;
      if (ov[d] !== 1'b1 || outv[d] !== e.res || ir[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure d%0d cyc%0d: ov=%b out=%b ir=%b required 1 %b 0",
                 d, h, ov[d], outv[d], ir[d], e.res);
      end
    end
    iv[d] = 1'b0;
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    vectors++;
    if (ov[d] !== 1'b0 || ir[d] !== 1'b1 || outv[d] !== e.res) begin
      miscompares++;
      $display("FAIL handoff d%0d: ov=%b ir=%b out=%b required 0 1 %b", d, ov[d], ir[d], outv[d], e.res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iv = '0; ordy = '0; num1 = '0; num2 = '0; sgn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || outv[d] !== 4'b0000 || co[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state d%0d: ir=%b ov=%b out=%b cout=%b required 1 0 0000 0",
                 d, ir[d], ov[d], outv[d], co[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    run_op(0, 16'h1234, 16'h1235, 1'b0, 0);
    run_op(0, 16'h8000, 16'h7FFF, 1'b0, 0);
    run_op(0, 16'hABCD, 16'hABCD, 1'b0, 0);
    run_op(0, 16'h0000, 16'h0000, 1'b0, 0);
    run_op(0, 16'h12F4, 16'h1204, 1'b0, 0);
  endtask

  task automatic test_signed();
    run_op(0, 16'h8000, 16'h7FFF, 1'b1, 0);
    run_op(0, 16'hABCD, 16'hABCD, 1'b1, 0);
    run_op(0, 16'h0000, 16'h0000, 1'b1, 0);
    run_op(0, 16'hFFFF, 16'h0001, 1'b1, 0);
    run_op(0, 16'h7FFF, 16'h8000, 1'b1, 0);
    run_op(0, 16'hFFF0, 16'hFFF1, 1'b1, 0);
  endtask

  task automatic test_no_early();
    for (int d = 1; d < 4; d++) begin
      run_op(d, 16'hF000, 16'h0000, 1'b0, 0);
      run_op(d, 16'h8000, 16'h0001, 1'b1, 0);
      run_op(d, 16'h5A5A, 16'h5A5A, 1'b1, 0);
    end
  endtask

  task automatic test_backpressure();
    run_op(0, 16'h4321, 16'h4320, 1'b0, 5);
    run_op(0, 16'h0010, 16'h0100, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      b = (i % 3 == 0) ? {a[15:8], 8'($urandom)} : 16'($urandom);
      run_op(i % 4, a, b, 1'($urandom), i % 3);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    num1 = 16'hABCD; num2 = 16'hABCD; sgn = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (outv[0] !== 4'b0000 || ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: out=%b ov=%b ir=%b required 0000 0 1", outv[0], ov[0], ir[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      vectors++;
      if (ov[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_discard: out_valid=%b required 0", ov[0]);
      end
    end
    run_op(0, 16'hFFFF, 16'h0001, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_no_early();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/comparator_seq.md
# comparator_seq

Sequential, parametrised magnitude comparator for the ALU datapath, generalising the 4-bit ripple comparator to WIDTH-bit operands. It compares operands CHUNK bits per clock, MSB chunk first, in unsigned or two's-complement signed mode. It stops early when it finds a difference, and uses a valid/ready handshake on both sides. Results use the ALU's standard 4-bit result format, so the block drops into the ALU result mux beside the other ops.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 ≤ CHUNK ≤ WIDTH.
- EARLY_EXIT, 1, 1 = finish on the first unequal chunk; 0 = always scan all chunks (constant latency).

Derived: NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- num1  in  WIDTH  operand A.
- num2  in  WIDTH  operand B.
- sgn  in  1  1 = signed (two's complement) compare; 0 = unsigned.
- in_valid  in  1  operands and sgn are valid.
- in_ready  out  1  block can accept an operation.
- out  out  4  result {1'b0, gt, lt, eq}: A>B, A<B, A==B.
- cout  out  1  always 0, per the ALU result format.
- out_valid  out  1  out holds a valid result.
- out_ready  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE, CMP, DONE. Reset state is IDLE.
- IDLE: in_ready=1. If in_valid, the block latches num1, num2 and sgn, sets idx=NCHUNK-1 and moves to CMP. Operand inputs are don't-care after accept.
- Signed mode: the latched MSB of both operands is inverted at capture. This turns the signed order into an unsigned order, and everything after that is an unsigned compare.
- CMP: each cycle compares chunk[idx] of A and B. Sticky flags gt/lt, both cleared at accept:
  - If gt|lt is already set, the flags hold.
  - Otherwise gt is set if chunkA>chunkB, and lt is set if chunkA<chunkB.
- CMP exit:
  - If EARLY_EXIT=1 and the chunk is unequal, or if idx==0: register out={0,gt',lt',eq'}, where eq' = ~gt' & ~lt' and the primed values include this cycle's compare. Then go to DONE.
  - Otherwise decrement idx and stay in CMP.
- DONE: out_valid=1, and out is held stable. When out_ready is high, go to IDLE. out keeps its value, out_valid drops.
- in_ready=0 in CMP and DONE. An in_valid arriving while the DONE→IDLE handoff completes is accepted on the following IDLE cycle, not the same cycle.
- Exactly one of out[2:0] is set while out_valid=1. out[3] and cout are constant 0.
- Reset asserted at any time (including mid-CMP or in DONE) immediately aborts the operation and discards its result. No partial result is emitted.

## Timing
- Reset values: state=IDLE, in_ready=1, out=4'b0000, out_valid=0, cout=0, idx=0, gt=lt=0.
- Accept occurs at edge e0 (in_valid & in_ready).
- Let k = the number of chunks examined. With EARLY_EXIT=1, k is 1 + the number of leading equal chunks, capped at NCHUNK. With EARLY_EXIT=0, k = NCHUNK.
- The result is registered at edge e0+k, and out_valid is high from the cycle after e0+k.
- Result handoff occurs at the edge where out_valid & out_ready are both high. The earliest next accept is one edge later.
- Throughput is one op per k+2 cycles at best.
- out changes only at the edge that enters DONE, or at reset.
- Boundaries:
  - WIDTH==CHUNK: a single CMP cycle.
  - CHUNK==1: bit-serial operation.
  - idx wraps never; the FSM leaves CMP at idx==0.

## Test plan
- Unsigned, WIDTH=16, CHUNK=4, EARLY_EXIT=1: A=0x1234, B=0x1235 → out=4'b0010 (lt), out_valid 4 cycles after accept.
- A=0x8000, B=0x7FFF: with sgn=0 → out=4'b0100 (gt) after 1 cycle; with sgn=1 → out=4'b0010 (lt) after 1 cycle.
- A=B=0xABCD and A=B=0x0000, both modes → out=4'b0001 (eq) after 4 cycles.
- EARLY_EXIT=0: A=0xF000, B=0x0000 → gt after exactly 4 cycles. Also sweep CHUNK=1 (16 cycles) and CHUNK=16 (1 cycle).
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out and out_valid stay stable, in_ready=0, and in_valid pulses are ignored. Raise out_ready → IDLE next cycle, and the next op is accepted.
- Assert rst during CMP at idx=2 → next cycle shows out=0, out_valid=0, in_ready=1. Then a fresh compare of A=-1 vs B=1 with sgn=1 returns lt.
